// File: rtl/posit_sum_stream_normalize.sv
// Normalizes raw serialized es=2 posit sums from positadd_4_raw into N-bit posits
// through a 2-stage pipeline, then buffers them in a small valid/ready FIFO.
module posit_sum_stream_normalize #(
  parameter int N     = 32,
  parameter int ES    = 2,
  parameter int SUM_W = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SUM_W-1:0] in_raw,
  input  logic             in_done,
  input  logic             in_truncated,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [15:0]      result_count
);

  localparam int SCALE_W = 8;
  localparam int GRD_W   = 4;
  localparam int FRAC_W  = SUM_W - 1 - SCALE_W - GRD_W - 2;
  localparam int TAIL_W  = ES + FRAC_W + GRD_W;
  localparam int PAD_W   = N;
  localparam int X_W     = 2 + TAIL_W + PAD_W;
  localparam int AW      = $clog2(DEPTH);

  localparam logic signed [SCALE_W-1:0] MAX_SCALE = SCALE_W'((N - 2) << ES);
  localparam logic signed [SCALE_W-1:0] MIN_SCALE = SCALE_W'(-((N - 2) << ES));
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic              sign;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0] frac;
    logic [GRD_W-1:0]  grd;
    logic              inf;
    logic              zero;
  } raw_t;

  // Stage 1: capture the adder output on in_done.
  logic             s1_valid_q;
  logic [SUM_W-1:0] s1_raw_q;
  logic             s1_trunc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_trunc_q <= 1'b0;
    end else begin
      s1_valid_q <= in_done;
      if (in_done) begin
        s1_raw_q   <= in_raw;
        s1_trunc_q <= in_truncated;
      end
    end
  end

  // Stage 2 combinational encoder: regime/exponent/fraction placement and RNE.
  raw_t                      f;
  logic signed [SCALE_W-1:0] scale_s;
  logic        [SCALE_W-1:0] k;
  logic                      k_neg;
  logic        [SCALE_W-1:0] sh;
  logic signed [X_W-1:0]     x_s;
  logic        [X_W-1:0]     y;
  logic        [N-2:0]       body;
  logic                      rnd_bit;
  logic                      sticky;
  logic                      round_up;
  logic        [N-1:0]       rounded;
  logic        [N-1:0]       mag;
  logic        [N-1:0]       norm_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    f        = raw_t'(s1_raw_q);
    scale_s  = f.scale;
    k        = scale_s >>> ES;
    k_neg    = k[SCALE_W-1];
    // Seeding with 10 (k>=0) or 01 (k<0) and sign-extending by k or ~k yields
    // exactly k+1 ones then a zero, or -k zeros then a one.
    sh       = k_neg ? ~k : k;
    x_s      = {(k_neg ? 2'b01 : 2'b10), f.scale[ES-1:0], f.frac, f.grd, {PAD_W{1'b0}}};
    y        = x_s >>> sh;
    body     = y[X_W-1 -: N-1];
    rnd_bit  = y[X_W-N];
    sticky   = (|y[X_W-N-1:0]) | s1_trunc_q;
    round_up = rnd_bit & (sticky | body[0]);
    rounded  = {1'b0, body} + {{(N-1){1'b0}}, round_up};

    mag = rounded;
    if (scale_s > MAX_SCALE || rounded[N-1]) begin
      mag = MAXPOS;
    end else if (scale_s < MIN_SCALE || rounded == '0) begin
      mag = MINPOS;
    end

    norm_d = f.sign ? (~mag + MINPOS) : mag;
    if (f.inf) begin
      norm_d = NAR;
    end else if (f.zero) begin
      norm_d = '0;
    end
  end

  logic         s2_valid_q;
  logic [N-1:0] s2_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= norm_d;
    end
  end

  // Output FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [N-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   count_q, count_d;
  logic          empty, full, pop, push, drop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && out_ready;
    push     = s2_valid_q && (!full || pop);
    drop     = s2_valid_q && full && !pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d  = count_q + {15'd0, push};
    overflow_d = overflow_q | drop;

    // The head register follows the entry at rd_ptr_d; when that slot is the
    // one being written this cycle, forward the incoming result instead.
    out_data_d = out_data_q;
    if (push && rd_ptr_d == wr_ptr_q) begin
      out_data_d = s2_data_q;
    end else if (pop && rd_ptr_d != wr_ptr_q) begin
      out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // alone, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s2_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = !empty;
  assign overflow     = overflow_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_posit_sum_stream_normalize.sv
// Directed bench for posit_sum_stream_normalize: encoding vectors, latency,
// FIFO full/overflow behaviour and mid-stream reset.
module tb_posit_sum_stream_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic [41:0] in_raw;
  logic        in_done;
  logic        in_truncated;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [15:0] result_count;

  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  int          exp_count = 0;
  logic [31:0] exp_q[$];

  posit_sum_stream_normalize #(.N(32), .ES(2), .SUM_W(42), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_raw       (in_raw),
    .in_done      (in_done),
    .in_truncated (in_truncated),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] mk_raw(input bit sgn, input logic [7:0] scale,
                                         input logic [26:0] frac, input logic [3:0] grd,
                                         input bit inf, input bit zero);
    return {sgn, scale, frac, grd, inf, zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [41:0] raw, input logic tr, input logic [31:0] exp, input bit keep);
    in_raw       = raw;
    in_truncated = tr;
    in_done      = 1'b1;
    if (keep) begin
      exp_q.push_back(exp);
      exp_count++;
    end
    tick();
    in_done = 1'b0;
  endtask

  // Every accepted output must match the next expected result in order.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed %h expected no output", out_data);
      end
      if (exp_q.size() > 0) check("pop_data", out_data, exp_q.pop_front());
      pop_count++;
    end
  end

  int          pops_before;
  logic [31:0] ramp[4] = '{32'h40000000, 32'h48000000, 32'h50000000, 32'h58000000};

  initial begin
    reset        = 1'b1;
    in_raw       = '0;
    in_done      = 1'b0;
    in_truncated = 1'b0;
    out_ready    = 1'b0;

    // Reset state
    #2;
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    check("rst_count", {16'b0, result_count}, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // Latency: done at edge t, visible after edge t+2
    send(mk_raw(0, 8'd0, 27'd0, 4'd0, 0, 0), 1'b0, 32'h40000000, 1);
    tick();
    check("lat_not_yet", {31'b0, out_valid}, 32'h0);
    tick();
    check("lat_valid", {31'b0, out_valid}, 32'h1);
    check("lat_data", out_data, 32'h40000000);
    out_ready = 1'b1;
    tick();
    check("lat_drained", {31'b0, out_valid}, 32'h0);

    // Encoding vectors, back to back with the consumer always ready
    send(mk_raw(0, 8'd1,   27'd0,         4'd0,    0, 0), 1'b0, 32'h48000000, 1);
    send(mk_raw(1, 8'd0,   27'd0,         4'd0,    0, 0), 1'b0, 32'hC0000000, 1);
    send(mk_raw(0, 8'd0,   27'd0,         4'd0,    0, 1), 1'b0, 32'h00000000, 1);
    send(mk_raw(0, 8'd0,   27'd0,         4'd0,    1, 1), 1'b0, 32'h80000000, 1);
    send(mk_raw(0, 8'd127, 27'd0,         4'd0,    0, 0), 1'b0, 32'h7FFFFFFF, 1);
    send(mk_raw(1, 8'h80,  27'd0,         4'd0,    0, 0), 1'b0, 32'hFFFFFFFF, 1);
    send(mk_raw(0, 8'd0,   27'h7FFFFFF,   4'b1000, 0, 0), 1'b0, 32'h48000000, 1);
    send(mk_raw(0, 8'hFF,  27'd0,         4'd0,    0, 0), 1'b0, 32'h38000000, 1);
    send(mk_raw(0, 8'd4,   27'd0,         4'd0,    0, 0), 1'b0, 32'h60000000, 1);
    send(mk_raw(0, 8'd0,   27'h7FFFFFF,   4'd0,    0, 0), 1'b1, 32'h47FFFFFF, 1);
    send(mk_raw(0, 8'd0,   27'd0,         4'b1000, 0, 0), 1'b0, 32'h40000000, 1);
    send(mk_raw(0, 8'd0,   27'd0,         4'b1000, 0, 0), 1'b1, 32'h40000001, 1);
    send(mk_raw(0, 8'd120, 27'd0,         4'd0,    0, 0), 1'b0, 32'h7FFFFFFF, 1);
    send(mk_raw(0, 8'h88,  27'd0,         4'd0,    0, 0), 1'b0, 32'h00000001, 1);
    send(mk_raw(1, 8'd121, 27'd0,         4'd0,    0, 0), 1'b0, 32'h80000001, 1);
    send(mk_raw(0, 8'h87,  27'd0,         4'd0,    0, 0), 1'b0, 32'h00000001, 1);
    send(mk_raw(0, 8'd2,   27'h4000000,   4'd0,    0, 0), 1'b0, 32'h54000000, 1);
    send(mk_raw(1, 8'd1,   27'd0,         4'd0,    0, 0), 1'b0, 32'hB8000000, 1);
    send(mk_raw(0, 8'd3,   27'h7FFFFFF,   4'b1000, 0, 0), 1'b0, 32'h60000000, 1);
    send(mk_raw(0, 8'd119, 27'd0,         4'd0,    0, 0), 1'b0, 32'h7FFFFFFF, 1);
    repeat (4) tick();
    check("vec_all_out", exp_q.size(), 32'd0);

    // 100 consecutive results at full throughput
    pops_before = pop_count;
    for (int i = 0; i < 100; i++) begin
      send(mk_raw(0, 8'(i % 4), 27'd0, 4'd0, 0, 0), 1'b0, ramp[i % 4], 1);
    end
    repeat (4) tick();
    check("stream_pops", pop_count - pops_before, 32'd100);
    check("stream_overflow", {31'b0, overflow}, 32'h0);
    check("stream_count", {16'b0, result_count}, exp_count);

    // Full FIFO with push and pop on the same edge: nothing lost
    out_ready   = 1'b0;
    pops_before = pop_count;
    for (int i = 0; i < 4; i++) begin
      send(mk_raw(0, 8'(i), 27'd0, 4'd0, 0, 0), 1'b0, ramp[i], 1);
    end
    send(mk_raw(0, 8'd4, 27'd0, 4'd0, 0, 0), 1'b0, 32'h60000000, 1);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    check("full_pushpop_pops", pop_count - pops_before, 32'd5);
    check("full_pushpop_overflow", {31'b0, overflow}, 32'h0);
    check("full_pushpop_count", {16'b0, result_count}, exp_count);

    // Push while full without pop: fifth result dropped
    out_ready = 1'b0;
    send(mk_raw(0, 8'd1,   27'd0, 4'd0, 0, 0), 1'b0, 32'h48000000, 1);
    send(mk_raw(1, 8'd0,   27'd0, 4'd0, 0, 0), 1'b0, 32'hC0000000, 1);
    send(mk_raw(0, 8'd4,   27'd0, 4'd0, 0, 0), 1'b0, 32'h60000000, 1);
    send(mk_raw(0, 8'hFF,  27'd0, 4'd0, 0, 0), 1'b0, 32'h38000000, 1);
    send(mk_raw(0, 8'd127, 27'd0, 4'd0, 0, 0), 1'b0, 32'h7FFFFFFF, 0);
    repeat (2) tick();
    check("ovf_flag", {31'b0, overflow}, 32'h1);
    check("ovf_count", {16'b0, result_count}, exp_count);
    check("ovf_valid", {31'b0, out_valid}, 32'h1);
    check("ovf_head_hold", out_data, 32'h48000000);
    tick();
    check("ovf_head_still", out_data, 32'h48000000);
    out_ready = 1'b1;
    repeat (6) tick();
    check("ovf_drained", {31'b0, out_valid}, 32'h0);
    check("ovf_all_out", exp_q.size(), 32'd0);
    check("ovf_sticky", {31'b0, overflow}, 32'h1);

    // Reset with one entry held and two results in flight
    out_ready = 1'b0;
    send(mk_raw(0, 8'd1, 27'd0, 4'd0, 0, 0), 1'b0, 32'h48000000, 0);
    send(mk_raw(0, 8'd2, 27'd0, 4'd0, 0, 0), 1'b0, 32'h50000000, 0);
    send(mk_raw(0, 8'd3, 27'd0, 4'd0, 0, 0), 1'b0, 32'h58000000, 0);
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_overflow", {31'b0, overflow}, 32'h0);
    check("mid_rst_count", {16'b0, result_count}, 32'h0);
    exp_count = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    out_ready   = 1'b1;
    pops_before = pop_count;
    repeat (5) tick();
    check("post_rst_quiet", {31'b0, out_valid}, 32'h0);
    check("post_rst_pops", pop_count - pops_before, 32'd0);
    send(mk_raw(0, 8'd1, 27'd0, 4'd0, 0, 0), 1'b0, 32'h48000000, 1);
    repeat (4) tick();
    check("post_rst_pops_new", pop_count - pops_before, 32'd1);
    check("post_rst_count", {16'b0, result_count}, exp_count);
    check("post_rst_all_out", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
